// File: rtl/reg_bank_if.sv
// Write/read bus of the cleared register bank: one write port, two read ports
// that share a single read enable, plus the bank status outputs.
interface reg_bank_if #(
   parameter int IN_ADDR_WIDTH  = 9,
   parameter int OUT_ADDR_WIDTH = 7,
   parameter int DATA_WIDTH     = 16
) ();
   logic                      Wr_En;
   logic [IN_ADDR_WIDTH-1:0]  Addr_In;
   logic [DATA_WIDTH-1:0]     Data_In;
   logic                      Rd_En;
   logic [OUT_ADDR_WIDTH-1:0] Addr_Out_A;
   logic [OUT_ADDR_WIDTH-1:0] Addr_Out_B;
   logic [DATA_WIDTH-1:0]     Data_Out_A;
   logic [DATA_WIDTH-1:0]     Data_Out_B;
   logic                      Rd_Valid;
   logic                      Busy;
   logic                      Wr_Err;

   modport master (
      output Wr_En, Addr_In, Data_In, Rd_En, Addr_Out_A, Addr_Out_B,
      input  Data_Out_A, Data_Out_B, Rd_Valid, Busy, Wr_Err
   );

   modport slave (
      input  Wr_En, Addr_In, Data_In, Rd_En, Addr_Out_A, Addr_Out_B,
      output Data_Out_A, Data_Out_B, Rd_Valid, Busy, Wr_Err
   );
endinterface

// File: rtl/reg_bank.sv
// Register bank with one windowed write port and two registered read ports;
// every reset sweeps the storage to zero before accepting traffic.
module reg_bank #(
   parameter int IN_ADDR_WIDTH     = 9,
   parameter int OUT_ADDR_WIDTH    = 7,
   parameter int ACTUAL_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH        = 16
) (
   input logic       clk,
   input logic       rst,
   reg_bank_if.slave bus
);
   localparam int REG_DEPTH = 1 << ACTUAL_ADDR_WIDTH;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                       state, state_nxt;
   logic [ACTUAL_ADDR_WIDTH-1:0] clr_cnt;
   logic [DATA_WIDTH-1:0]        mem [REG_DEPTH];

   logic                         busy, wr_ok, wr_reject, rd_ok;
   logic                         a_in_win, b_in_win;
   logic [ACTUAL_ADDR_WIDTH-1:0] wr_idx, a_idx, b_idx;
   logic [DATA_WIDTH-1:0]        a_data, b_data;
   logic [DATA_WIDTH-1:0]        data_a_q, data_b_q;
   logic                         rd_valid_q, wr_err_q;

   always_ff @(posedge clk) begin
      if (rst) state <= CLEAR;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_cnt == '1) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   always_comb begin
      busy      = (state != RUN);
      wr_idx    = bus.Addr_In[ACTUAL_ADDR_WIDTH-1:0];
      a_idx     = bus.Addr_Out_A[ACTUAL_ADDR_WIDTH-1:0];
      b_idx     = bus.Addr_Out_B[ACTUAL_ADDR_WIDTH-1:0];
      a_in_win  = (bus.Addr_Out_A[OUT_ADDR_WIDTH-1:ACTUAL_ADDR_WIDTH] == '0);
      b_in_win  = (bus.Addr_Out_B[OUT_ADDR_WIDTH-1:ACTUAL_ADDR_WIDTH] == '0);
      wr_ok     = !busy && bus.Wr_En && (bus.Addr_In[IN_ADDR_WIDTH-1:ACTUAL_ADDR_WIDTH] == '0);
      wr_reject = !busy && bus.Wr_En && (bus.Addr_In[IN_ADDR_WIDTH-1:ACTUAL_ADDR_WIDTH] != '0);
      rd_ok     = !busy && bus.Rd_En;
      // write-first: a same-cycle write to the addressed entry bypasses storage
      a_data = '0;
      if (a_in_win) a_data = (wr_ok && wr_idx == a_idx) ? bus.Data_In : mem[a_idx];
      b_data = '0;
      if (b_in_win) b_data = (wr_ok && wr_idx == b_idx) ? bus.Data_In : mem[b_idx];
   end

   // clr_cnt wraps back to zero on the edge that leaves CLEAR
   always_ff @(posedge clk) begin
      if (rst)       clr_cnt <= '0;
      else if (busy) clr_cnt <= clr_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (busy)       mem[clr_cnt] <= '0;
         else if (wr_ok) mem[wr_idx]  <= bus.Data_In;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         wr_err_q   <= 1'b0;
         data_a_q   <= '0;
         data_b_q   <= '0;
      end else begin
         rd_valid_q <= rd_ok;
         wr_err_q   <= wr_reject;
         if (rd_ok) begin
            data_a_q <= a_data;
            data_b_q <= b_data;
         end
      end
   end

   assign bus.Busy       = busy;
   assign bus.Rd_Valid   = rd_valid_q;
   assign bus.Wr_Err     = wr_err_q;
   assign bus.Data_Out_A = data_a_q;
   assign bus.Data_Out_B = data_b_q;
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter IN_ADDR_WIDTH, default 9, width of write address.
REQ-002 Parameter OUT_ADDR_WIDTH, default 7, width of each read address.
REQ-003 Parameter ACTUAL_ADDR_WIDTH, default 5, decoded address bits; REG_DEPTH = 1<<ACTUAL_ADDR_WIDTH entries.
REQ-004 Parameter DATA_WIDTH, default 16, width of every storage entry and data port.
REQ-005 clk  in  1  single clock; all state SHALL update on rising edge only.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 Wr_En  in  1  write request.
REQ-008 Addr_In  in  IN_ADDR_WIDTH  write address.
REQ-009 Data_In  in  DATA_WIDTH  write data.
REQ-010 Rd_En  in  1  read request, both ports.
REQ-011 Addr_Out_A, Addr_Out_B  in  OUT_ADDR_WIDTH  read addresses, ports A/B.
REQ-012 Data_Out_A, Data_Out_B  out  DATA_WIDTH  registered read data.
REQ-013 Rd_Valid  out  1  Data_Out_A/B valid for the accepted read.
REQ-014 Busy  out  1  high while the bank is being cleared.
REQ-015 Wr_Err  out  1  one-cycle pulse: write outside window rejected.

Function
REQ-016 Storage SHALL be REG_DEPTH entries of DATA_WIDTH bits each.
REQ-017 Two-state FSM: CLEAR, RUN; CLEAR entered on any edge with rst=1.
REQ-018 CLEAR: counter starts at 0; each edge with rst=0 writes 0 to entry[counter], counter+1; edge writing entry REG_DEPTH-1 moves FSM to RUN.
REQ-019 Busy SHALL be registered, 1 in CLEAR, 0 in RUN; Busy falls on the REG_DEPTH-th edge after rst deasserts (32 for defaults).
REQ-020 In CLEAR, Wr_En and Rd_En SHALL be ignored; Rd_Valid=0, Wr_Err=0.
REQ-021 RUN write: Wr_En=1 and Addr_In[IN_ADDR_WIDTH-1:ACTUAL_ADDR_WIDTH]==0 -> entry[Addr_In[ACTUAL_ADDR_WIDTH-1:0]] <= Data_In.
REQ-022 RUN write with upper Addr_In bits nonzero: no storage change; Wr_Err=1 the following cycle only.
REQ-023 RUN read: Rd_En=1 -> next edge loads Data_Out_A/B and sets Rd_Valid=1; latency exactly 1 cycle.
REQ-024 Read address with upper bits (OUT_ADDR_WIDTH-1:ACTUAL_ADDR_WIDTH) nonzero SHALL return 0 on that port.
REQ-025 Same-cycle write and read of same in-window entry SHALL return the new Data_In (write-first forwarding), independently per port.
REQ-026 Rd_En=0: Rd_Valid=0 next cycle; Data_Out_A/B hold last value.
REQ-027 Ports A and B MAY address the same entry; both SHALL return identical data.
REQ-028 Rd_En and Wr_En accepted every cycle in RUN; no back-pressure.
REQ-029 Storage not reset directly; contents defined only via CLEAR sweep.

Reset
REQ-030 Edge with rst=1: FSM=CLEAR, counter=0, Busy=1, Rd_Valid=0, Wr_Err=0, Data_Out_A=0, Data_Out_B=0.
REQ-031 rst during CLEAR restarts sweep from entry 0; rst during RUN discards in-flight read (Rd_Valid=0 next cycle) and re-clears all entries.
REQ-032 rst has priority over Wr_En/Rd_En on the same edge.

Verification
REQ-033 Release rst, idle -> Busy=1 for 32 edges then 0; read all 32 entries -> all 0.
REQ-034 RUN: write 0xBEEF to Addr_In=5, read Addr_Out_A=5, Addr_Out_B=6 next cycle -> one cycle later Data_Out_A=0xBEEF, Data_Out_B=0, Rd_Valid=1.
REQ-035 Same cycle write 0x1234 to 9 and read A=9,B=9 -> next cycle both 0x1234.
REQ-036 Write 0xAAAA to Addr_In=0x020 -> Wr_Err pulses 1 cycle, entry 0 unchanged; read Addr_Out_A=0x20 -> 0.
REQ-037 Write 0x5555 to entry 3, assert rst at clear count 10 of a later sweep -> Busy remains 1 a further 32 edges; entry 3 reads 0.
REQ-038 Wr_En/Rd_En asserted while Busy=1 -> no storage change, Rd_Valid stays 0.
